reg_reader: RTL and testbench
=============================

# reg_reader

Register-read stage of the core: accepts a decoded instruction's two source selectors and destination selector, reads operands from the 32-entry unified register file (16 general + 16 float), and hands them to execute through a valid/ready register slice. It is the read-side counterpart of `reg_writer`. It keeps a pending-write scoreboard, stalls issue on RAW/WAW hazards, and snoops the writeback port to clear hazards and optionally forward data.

## Interface
- No parameters; sizes are fixed by package constants.
- `clk`  in  1  system clock; all state updates on rising edge
- `rstn`  in  1  synchronous, active-low reset
- `in_valid`  in  1  issue request valid
- `in_ready`  out  1  stage accepts request this cycle
- `rs1_gf`, `rs2_gf`, `rd_gf`  in  1 each  0: general, 1: float
- `rs1_num`, `rs2_num`, `rd_num`  in  4 each  register number within file
- `rd_we`  in  1  instruction will write `rd`
- `regs`  in  32×32 (unpacked `[0:31]`)  register file contents, index `{gf,num}`
- `w_gfflag`  in  1  writeback file select (same meaning as writer)
- `w_num`  in  4  writeback register number
- `w_data`  in  32  writeback data
- `w_enable`  in  1  writeback commits this cycle; `regs` shows it next cycle
- `out_valid`  out  1  operands valid to execute
- `out_ready`  in  1  execute accepts operands
- `op1`, `op2`  out  32 each  operand values

## Operation
- Index = `{gf,num}`, 5 bits. Index 0 (general r0) always reads 0, is never marked busy, never causes a hazard.
- Scoreboard: 32 busy bits. Set on accept when `rd_we` and rd index ≠ 0. Cleared when `w_enable` and index matches. Same-cycle set and clear of one index: set wins.
- Hazard for a source: busy bit set and not cleared by a matching `w_enable` this cycle (with bypass) / busy bit set or matching `w_enable` this cycle (without bypass).
- WAW: rd busy stalls under the same rule as a source.
- `in_ready` = (`!out_valid` || `out_ready`) && no hazard on rs1, rs2 or rd. `in_ready` is independent of `in_valid`.
- Accept = `in_valid && in_ready`. On accept: `op1`/`op2` load operand value (0 for index 0; `w_data` when bypass forwards; else `regs[index]`). `out_valid` ← 1.
- If no accept and `out_ready`, `out_valid` ← 0. While `out_valid && !out_ready`, `op1`/`op2`/`out_valid` hold.

## Timing
- Reset (`rstn`=0 at edge): `out_valid`=0, `op1`=`op2`=0, all busy bits 0. Reset mid-stall discards the held operands and all pending marks.
- Latency: accept at edge N → `out_valid` and operands visible after edge N.
- Throughput: one per cycle when no hazard and `out_ready`=1.
- Writeback on the same cycle as a dependent issue: forwarded with bypass; one-cycle stall without.

## Configuration
- `REG_READER_BYPASS_EN` defined: `w_data` is forwarded to a matching source in the writeback cycle, clearing the hazard that cycle.
- Undefined: no forwarding mux; a source or rd matching an active `w_enable` stalls until `regs` reflects the write (next cycle).

## Structure
- Shared `reg_pkg`: `reg_idx_t` (5-bit `{gf,num}`), `REG_NUM`=32, `REG_W`=32, `REG_ZERO`=5'd0.
- One sub-module: `reg_scoreboard` (busy bits, set/clear, hazard lookup for three indices).

## Test plan
- Reset then issue rs1=g3, rs2=f2 with `regs[3]`=0x11, `regs[18]`=0x22 → next cycle `out_valid`=1, `op1`=0x11, `op2`=0x22.
- Issue rd=g5 `rd_we`=1, then issue rs1=g5 → `in_ready`=0 until `w_enable` g5 with `w_data`=0xABCD; with bypass accepted that cycle, `op1`=0xABCD; without, accepted next cycle reading `regs[5]`.
- Issue rs1=g0, rd=g0 `rd_we`=1, `regs[0]`=0xFFFF → `op1`=0, no busy bit set, following g0 reads never stall.
- `out_ready`=0 for 3 cycles after accept → `op1`/`op2`/`out_valid` held, `in_ready`=0; back-to-back throughput resumes when `out_ready`=1.
- Writeback clears f1 while same-cycle issue sets rd=f1 → busy[17] remains 1; later read of f1 stalls.
- Assert `rstn`=0 with busy bits set and `out_valid`=1 → next cycle all outputs 0, no stalls.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared register-file types and sizes for the read/write stages.
// The forwarding option REG_READER_BYPASS_EN is consumed in reg_reader/reg_scoreboard.
package reg_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_W   = 32;

  typedef logic [4:0]       reg_idx_t;
  typedef logic [REG_W-1:0] reg_word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  function automatic reg_idx_t reg_idx(
    input logic       gf,
    input logic [3:0] num
  );
    return {gf, num};
  endfunction

  function automatic logic [REG_NUM-1:0] reg_onehot(
    input logic     en,
    input reg_idx_t idx
  );
    logic [REG_NUM-1:0] v;
    v = '0;
    if (en && idx != REG_ZERO) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write busy bits with hazard lookup for rs1, rs2 and rd.
// Hazard rule depends on REG_READER_BYPASS_EN (forwarding clears it).
module reg_scoreboard
  import reg_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rs1_idx,
  input  reg_idx_t rs2_idx,
  input  reg_idx_t rd_idx,
  output logic     rs1_haz,
  output logic     rs2_haz,
  output logic     rd_haz
);

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] set_vec;
  logic [REG_NUM-1:0] clr_vec;

  assign set_vec = reg_onehot(set_en, set_idx);
  assign clr_vec = reg_onehot(clr_en, clr_idx);

  // set is OR-ed in after the clear so a same-cycle set wins
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

  function automatic logic haz(
    input logic b,
    input logic hit
  );
`ifdef REG_READER_BYPASS_EN
    return b && !hit;
`else
    return b || hit;
`endif
  endfunction

  always_comb begin
    rs1_haz = haz(busy[rs1_idx], clr_vec[rs1_idx]);
    rs2_haz = haz(busy[rs2_idx], clr_vec[rs2_idx]);
    rd_haz  = haz(busy[rd_idx],  clr_vec[rd_idx]);
  end

endmodule

// File: rtl/reg_reader.sv
// Register-read stage: scoreboard-gated operand fetch into a valid/ready slice.
// Define REG_READER_BYPASS_EN to forward w_data in the writeback cycle.
module reg_reader
  import reg_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rs1_gf,
  input  logic             rs2_gf,
  input  logic             rd_gf,
  input  logic [3:0]       rs1_num,
  input  logic [3:0]       rs2_num,
  input  logic [3:0]       rd_num,
  input  logic             rd_we,
  input  logic [REG_W-1:0] regs [0:REG_NUM-1],
  input  logic             w_gfflag,
  input  logic [3:0]       w_num,
  input  logic [REG_W-1:0] w_data,
  input  logic             w_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] op1,
  output logic [REG_W-1:0] op2
);

  reg_idx_t  rs1_idx, rs2_idx, rd_idx, w_idx;
  logic      rs1_haz, rs2_haz, rd_haz;
  logic      rs1_fwd, rs2_fwd;
  logic      accept;
  reg_word_t op1_nxt, op2_nxt;

  assign rs1_idx = reg_idx(rs1_gf, rs1_num);
  assign rs2_idx = reg_idx(rs2_gf, rs2_num);
  assign rd_idx  = reg_idx(rd_gf, rd_num);
  assign w_idx   = reg_idx(w_gfflag, w_num);

  assign in_ready = (!out_valid || out_ready)
                 && !rs1_haz && !rs2_haz && !rd_haz;
  assign accept   = in_valid && in_ready;

  reg_scoreboard u_sb (
    .clk     (clk),
    .rstn    (rstn),
    .set_en  (accept && rd_we),
    .set_idx (rd_idx),
    .clr_en  (w_enable),
    .clr_idx (w_idx),
    .rs1_idx (rs1_idx),
    .rs2_idx (rs2_idx),
    .rd_idx  (rd_idx),
    .rs1_haz (rs1_haz),
    .rs2_haz (rs2_haz),
    .rd_haz  (rd_haz)
  );

`ifdef REG_READER_BYPASS_EN
  assign rs1_fwd = w_enable && w_idx == rs1_idx;
  assign rs2_fwd = w_enable && w_idx == rs2_idx;
`else
  assign rs1_fwd = 1'b0;
  assign rs2_fwd = 1'b0;
`endif

  function automatic reg_word_t pick(
    input logic      zero,
    input logic      fwd,
    input reg_word_t wd,
    input reg_word_t rf
  );
    reg_word_t v;
    unique case (1'b1)
      zero:    v = '0;
      fwd:     v = wd;
      default: v = rf;
    endcase
    return v;
  endfunction

  always_comb begin
    op1_nxt = pick(rs1_idx == REG_ZERO, rs1_fwd,
                   w_data, regs[rs1_idx]);
    op2_nxt = pick(rs2_idx == REG_ZERO, rs2_fwd,
                   w_data, regs[rs2_idx]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      op1       <= '0;
      op2       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      op1       <= op1_nxt;
      op2       <= op2_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_reader.sv
// Scenario bench for reg_reader with an expected-operand queue.
// Honours REG_READER_BYPASS_EN for writeback-cycle expectations.
module tb_reg_reader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        rs1_gf, rs2_gf, rd_gf;
  logic [3:0]  rs1_num, rs2_num, rd_num;
  logic        rd_we;
  logic [31:0] regs [0:31];
  logic        w_gfflag;
  logic [3:0]  w_num;
  logic [31:0] w_data;
  logic        w_enable;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op1, op2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_reader dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1_gf    (rs1_gf),
    .rs2_gf    (rs2_gf),
    .rd_gf     (rd_gf),
    .rs1_num   (rs1_num),
    .rs2_num   (rs2_num),
    .rd_num    (rd_num),
    .rd_we     (rd_we),
    .regs      (regs),
    .w_gfflag  (w_gfflag),
    .w_num     (w_num),
    .w_data    (w_data),
    .w_enable  (w_enable),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op1       (op1),
    .op2       (op2)
  );

  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected op1=%h op2=%h expected none", op1, op2);
      end else begin
        e = exp_q.pop_front();
        if (op1 !== e.a || op2 !== e.b) begin
          failures++;
          $display("FAIL sb_operands op1=%h op2=%h expected %h %h",
                   op1, op2, e.a, e.b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back({a, b});
  endtask

  task automatic set_src(input logic g1, input logic [3:0] n1,
                         input logic g2, input logic [3:0] n2);
    rs1_gf = g1; rs1_num = n1;
    rs2_gf = g2; rs2_num = n2;
  endtask

  task automatic set_rd(input logic g, input logic [3:0] n, input logic we);
    rd_gf = g; rd_num = n; rd_we = we;
  endtask

  task automatic wb(input logic g, input logic [3:0] n, input logic [31:0] d);
    w_gfflag = g; w_num = n; w_data = d; w_enable = 1'b1;
  endtask

  task automatic commit();
    if (w_enable) regs[{w_gfflag, w_num}] = w_data;
    w_enable = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_src(0, 0, 0, 0);
    set_rd(0, 0, 0);
    w_gfflag = 0; w_num = 0; w_data = 0; w_enable = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    tick();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (op1 !== 32'h0 || op2 !== 32'h0) begin
      failures++; $display("FAIL reset_ops got=%h %h exp=0 0", op1, op2);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    regs[3] = 32'h11;
    regs[18] = 32'h22;
    set_src(0, 3, 1, 2);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL basic_ready got=%b exp=1", in_ready);
    end else push(32'h11, 32'h22);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, op1, op2} !== {1'b1, 32'h11, 32'h22}) begin
      failures++;
      $display("FAIL basic_out got=%b %h %h exp=1 11 22", out_valid, op1, op2);
    end
    tick();
  endtask

  task automatic test_raw();
    regs[5] = 32'h55;
    set_src(0, 0, 0, 0);
    set_rd(0, 5, 1);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL raw_producer got=%b exp=1", in_ready);
    end else push(0, 0);
    tick();
    set_rd(0, 0, 0);
    set_src(0, 5, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL raw_stall got=%b exp=0", in_ready);
      end
      tick();
    end
    wb(0, 5, 32'hABCD);
    @(negedge clk);
`ifdef REG_READER_BYPASS_EN
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL raw_bypass got=%b exp=1", in_ready);
    end else push(32'hABCD, 0);
    tick();
    commit();
`else
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL raw_wb_stall got=%b exp=0", in_ready);
    end
    tick();
    commit();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL raw_release got=%b exp=1", in_ready);
    end else push(32'hABCD, 0);
    tick();
`endif
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL raw_cleared got=%b exp=1", in_ready);
    end else push(32'hABCD, 0);
    checks++;
    if ({out_valid, op1} !== {1'b1, 32'hABCD}) begin
      failures++;
      $display("FAIL raw_op1 got=%b %h exp=1 abcd", out_valid, op1);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_zero();
    regs[0] = 32'hFFFF;
    set_src(0, 0, 0, 0);
    set_rd(0, 0, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL zero_ready got=%b exp=1", in_ready);
      end else push(0, 0);
      tick();
    end
    wb(0, 0, 32'h1234);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL zero_wb got=%b exp=1", in_ready);
    end else push(0, 0);
    tick();
    w_enable = 1'b0;
    in_valid = 1'b0;
    set_rd(0, 0, 0);
    @(negedge clk);
    checks++;
    if (op1 !== 32'h0) begin
      failures++; $display("FAIL zero_op got=%h exp=0", op1);
    end
    tick();
  endtask

  task automatic test_hold();
    regs[1] = 32'h101;
    regs[2] = 32'h202;
    out_ready = 1'b0;
    set_src(0, 3, 1, 2);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL hold_first got=%b exp=1", in_ready);
    end else push(32'h11, 32'h22);
    tick();
    set_src(0, 1, 0, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, op1, op2} !== {1'b1, 32'h11, 32'h22}) begin
        failures++;
        $display("FAIL hold_data got=%b %h %h exp=1 11 22", out_valid, op1, op2);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL hold_stall got=%b exp=0", in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL hold_resume got=%b exp=1", in_ready);
    end else push(32'h101, 32'h202);
    tick();
    set_src(1, 2, 0, 3);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL back_to_back got=%b exp=1", in_ready);
    end else push(32'h22, 32'h11);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_set_clear();
    set_src(0, 0, 0, 0);
    set_rd(1, 1, 1);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL sc_mark got=%b exp=1", in_ready);
    end else push(0, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    tick();
    in_valid = 1'b1;
    wb(1, 1, 32'h66);
    @(negedge clk);
`ifdef REG_READER_BYPASS_EN
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL sc_same_cycle got=%b exp=1", in_ready);
    end else push(0, 0);
    tick();
    commit();
`else
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL sc_waw_stall got=%b exp=0", in_ready);
    end
    tick();
    commit();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL sc_waw_release got=%b exp=1", in_ready);
    end else push(0, 0);
    tick();
`endif
    set_rd(0, 0, 0);
    set_src(1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL sc_busy got=%b exp=0", in_ready);
      end
      tick();
    end
    wb(1, 1, 32'h77);
    @(negedge clk);
`ifdef REG_READER_BYPASS_EN
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL sc_read_fwd got=%b exp=1", in_ready);
    end else push(32'h77, 0);
    tick();
    commit();
`else
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL sc_read_wb got=%b exp=0", in_ready);
    end
    tick();
    commit();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL sc_read_release got=%b exp=1", in_ready);
    end else push(32'h77, 0);
    tick();
`endif
    in_valid = 1'b0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_src(0, 3, 0, 0);
    set_rd(0, 7, 1);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_issue got=%b exp=1", in_ready);
    end else push(32'h11, 0);
    tick();
    in_valid = 1'b0;
    set_rd(0, 0, 0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL mid_pending got=%b exp=1", out_valid);
    end
    tick();
    rstn = 1'b0;
    exp_q.delete();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, op1, op2} !== {1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL mid_reset got=%b %h %h exp=0 0 0", out_valid, op1, op2);
    end
    tick();
    regs[7] = 32'h700;
    out_ready = 1'b1;
    set_src(0, 7, 0, 7);
    set_rd(0, 7, 1);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_no_stall got=%b exp=1", in_ready);
    end else push(32'h700, 32'h700);
    tick();
    in_valid = 1'b0;
    set_rd(0, 0, 0);
    @(negedge clk);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_zero();
    test_hold();
    test_set_clear();
    test_reset_mid();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
